// File: rtl/alu_control_pkg.sv
// Shared encodings for the ALU control sequencer: ALUOp classes, funct codes,
// ALUOperation codes, FSM state encoding and the combinational decode helper.
package alu_control_pkg;

    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned CNT_W   = 8;

    // Operation class from main control
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b101;
    localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'b110;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b111;

    localparam logic [FUNCT_W-1:0] FN_SLL   = 6'b000000;
    localparam logic [FUNCT_W-1:0] FN_SRL   = 6'b000010;
    localparam logic [FUNCT_W-1:0] FN_JR    = 6'b001000;
    localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'b010000;
    localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'b010010;
    localparam logic [FUNCT_W-1:0] FN_MULT  = 6'b011000;
    localparam logic [FUNCT_W-1:0] FN_MULTU = 6'b011001;
    localparam logic [FUNCT_W-1:0] FN_DIV   = 6'b011010;
    localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'b011011;
    localparam logic [FUNCT_W-1:0] FN_ADD   = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB   = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND   = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR    = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_NOR   = 6'b100111;

    localparam logic [OPC_W-1:0] OPC_AND   = 4'b0000;
    localparam logic [OPC_W-1:0] OPC_OR    = 4'b0001;
    localparam logic [OPC_W-1:0] OPC_NOR   = 4'b0010;
    localparam logic [OPC_W-1:0] OPC_ADD   = 4'b0011;
    localparam logic [OPC_W-1:0] OPC_SUB   = 4'b0100;
    localparam logic [OPC_W-1:0] OPC_SLL   = 4'b0101;
    localparam logic [OPC_W-1:0] OPC_SRL   = 4'b0110;
    localparam logic [OPC_W-1:0] OPC_LUI   = 4'b0111;
    localparam logic [OPC_W-1:0] OPC_SLT   = 4'b1000;
    localparam logic [OPC_W-1:0] OPC_NONE  = 4'b1001;
    localparam logic [OPC_W-1:0] OPC_MULT  = 4'b1010;
    localparam logic [OPC_W-1:0] OPC_MULTU = 4'b1011;
    localparam logic [OPC_W-1:0] OPC_DIV   = 4'b1100;
    localparam logic [OPC_W-1:0] OPC_DIVU  = 4'b1101;
    localparam logic [OPC_W-1:0] OPC_MFHI  = 4'b1110;
    localparam logic [OPC_W-1:0] OPC_MFLO  = 4'b1111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef struct packed {
        logic [OPC_W-1:0] op;
        logic             jr;
        logic             illegal;
        logic             is_mult;
        logic             is_div;
    } decode_t;

    function automatic decode_t alu_decode(input logic [ALUOP_W-1:0] aluop,
                                           input logic [FUNCT_W-1:0] funct);
        decode_t d;
        // NOTE: every field gets a default before the case, so no path leaves a
        // bit unassigned and combinational callers never infer a latch.
        d = '{op: OPC_NONE, jr: 1'b0, illegal: 1'b1, is_mult: 1'b0, is_div: 1'b0};
        case (aluop)
            ALUOP_ADD: begin d.op = OPC_ADD; d.illegal = 1'b0; end
            ALUOP_OR:  begin d.op = OPC_OR;  d.illegal = 1'b0; end
            ALUOP_AND: begin d.op = OPC_AND; d.illegal = 1'b0; end
            ALUOP_SUB: begin d.op = OPC_SUB; d.illegal = 1'b0; end
            ALUOP_LUI: begin d.op = OPC_LUI; d.illegal = 1'b0; end
            ALUOP_SLT: begin d.op = OPC_SLT; d.illegal = 1'b0; end
            ALUOP_RTYPE: begin
                d.illegal = 1'b0;
                case (funct)
                    FN_AND:   d.op = OPC_AND;
                    FN_OR:    d.op = OPC_OR;
                    FN_NOR:   d.op = OPC_NOR;
                    FN_ADD:   d.op = OPC_ADD;
                    FN_SUB:   d.op = OPC_SUB;
                    FN_SLL:   d.op = OPC_SLL;
                    FN_SRL:   d.op = OPC_SRL;
                    FN_MFHI:  d.op = OPC_MFHI;
                    FN_MFLO:  d.op = OPC_MFLO;
                    FN_JR:    d.jr = 1'b1;
                    FN_MULT:  begin d.op = OPC_MULT;  d.is_mult = 1'b1; end
                    FN_MULTU: begin d.op = OPC_MULTU; d.is_mult = 1'b1; end
                    FN_DIV:   begin d.op = OPC_DIV;   d.is_div  = 1'b1; end
                    FN_DIVU:  begin d.op = OPC_DIVU;  d.is_div  = 1'b1; end
                    default:  d.illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// Request/response bundle between main control (master) and the ALU control
// sequencer (slave).
interface alu_control_seq_if;
    import alu_control_pkg::*;

    logic               in_valid;
    logic [ALUOP_W-1:0] ALUOp;
    logic [FUNCT_W-1:0] ALUFunction;
    logic               in_ready;
    logic [OPC_W-1:0]   ALUOperation;
    logic               out_valid;
    logic               JR;
    logic               md_start;
    logic               busy;
    logic               md_done;
    logic               illegal_op;

    modport master (
        output in_valid, ALUOp, ALUFunction,
        input  in_ready, ALUOperation, out_valid, JR, md_start, busy, md_done, illegal_op
    );

    modport slave (
        input  in_valid, ALUOp, ALUFunction,
        output in_ready, ALUOperation, out_valid, JR, md_start, busy, md_done, illegal_op
    );

endinterface

// File: rtl/md_cycle_counter.sv
// Busy-cycle countdown for multiply/divide: loads a cycle count, decrements
// while enabled and flags the final cycle (count == 1).
module md_cycle_counter
    import alu_control_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent logic.
    // NOTE: reset is synchronous -- only sampled on the rising clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: registered funct/ALUOp decode with an IDLE/BUSY stall
// FSM for multi-cycle MULT/DIV. Define ALU_CTRL_ILLEGAL_TRAP_EN for the sticky trap.
module alu_control_seq #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input logic              clk,
    input logic              reset,
    alu_control_seq_if.slave bus
);
    import alu_control_pkg::*;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [0:0]       state;
    logic             accept;
    logic             md_op;
    decode_t          dec;
    logic [OPC_W-1:0] op_q;
    logic             jr_q;
    logic             out_valid_q;
    logic             md_start_q;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt_value;
    logic [CNT_W-1:0] load_value;

    assign accept     = bus.in_valid && (state == ST_IDLE);
    assign dec        = alu_decode(bus.ALUOp, bus.ALUFunction);
    assign md_op      = dec.is_mult || dec.is_div;
    assign load_value = dec.is_div ? DIV_LOAD : MULT_LOAD;
    assign cnt_load   = accept && md_op;
    assign cnt_dec    = (state == ST_BUSY) && (cnt_value != '0);

    md_cycle_counter #(.WIDTH(CNT_W)) u_md_cycle_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (load_value),
        .dec        (cnt_dec),
        .count      (cnt_value),
        .last       (cnt_last)
    );

    // Requests arriving while BUSY are not accepted, so they never reach here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= OPC_NONE;
            jr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            md_start_q  <= 1'b0;
        end else begin
            out_valid_q <= accept;
            md_start_q  <= accept && md_op;
            if (accept) begin
                op_q <= dec.op;
                jr_q <= dec.jr;
            end
            if (state == ST_IDLE) begin
                if (accept && md_op) begin
                    state <= ST_BUSY;
                end
            end else if (cnt_last) begin
                state <= ST_IDLE;
            end
        end
    end

    assign bus.in_ready     = (state == ST_IDLE);
    assign bus.busy         = (state == ST_BUSY);
    assign bus.md_done      = (state == ST_BUSY) && cnt_last;
    assign bus.md_start     = md_start_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.ALUOperation = op_q;
    assign bus.JR           = jr_q;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (accept && dec.illegal) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal_op = illegal_q;
`else
    logic unused_illegal;

    assign unused_illegal = dec.illegal;
    assign bus.illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: directed requests push expected
// responses; a negedge monitor pops and compares against the DUT outputs.
module tb_alu_control_seq;

    typedef struct {
        logic [2:0] aop;
        logic [5:0] fn;
        logic [3:0] op;
        logic       jr;
        logic       ill;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [3:0] op;
        logic       jr;
        logic       ill;
    } out_exp_t;

    typedef struct {
        int start;
        int done;
    } md_exp_t;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    int         cyc       = 0;
    int         checks    = 0;
    int         errors    = 0;
    int         ready_at  = 0;
    logic [3:0] hold_op   = 4'b1001;
    logic       hold_jr   = 1'b0;
    logic       ill_model = 1'b0;
    logic       mon_en    = 1'b0;
    out_exp_t   out_q[$];
    md_exp_t    md_q[$];
    vec_t       vecs[18];

    alu_control_seq_if bus_a ();
    alu_control_seq_if bus_b ();

    alu_control_seq #(.MULT_CYCLES(4), .DIV_CYCLES(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    alu_control_seq #(.MULT_CYCLES(1), .DIV_CYCLES(1)) u_one (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic exp_ov;
        logic exp_ms;
        logic exp_md;
        logic exp_busy;
        if (mon_en) begin
            exp_ov = (out_q.size() > 0) && (out_q[0].cyc == cyc);
            check("out_valid", 32'(bus_a.out_valid), 32'(exp_ov));
            if (exp_ov) begin
                hold_op = out_q[0].op;
                hold_jr = out_q[0].jr;
                if (out_q[0].ill) ill_model = 1'b1;
                void'(out_q.pop_front());
            end
            check("ALUOperation", 32'(bus_a.ALUOperation), 32'(hold_op));
            check("JR", 32'(bus_a.JR), 32'(hold_jr));
            check("illegal_op", 32'(bus_a.illegal_op), 32'(ill_model));
            exp_busy = (cyc < ready_at);
            check("busy", 32'(bus_a.busy), 32'(exp_busy));
            check("in_ready", 32'(bus_a.in_ready), 32'(!exp_busy));
            exp_ms = (md_q.size() > 0) && (md_q[0].start == cyc);
            exp_md = (md_q.size() > 0) && (md_q[0].done == cyc);
            check("md_start", 32'(bus_a.md_start), 32'(exp_ms));
            check("md_done", 32'(bus_a.md_done), 32'(exp_md));
            if (exp_md) void'(md_q.pop_front());
        end
    end

    // Presents a request and keeps in_valid high until the model says the DUT
    // is idle; the edge closing that cycle is the accept edge.
    task automatic issue(input logic [2:0] aop, input logic [5:0] fn, input logic [3:0] eop,
                         input logic ejr, input logic eill, input int n, output int acc);
        logic ill_e;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        ill_e = eill;
`else
        ill_e = 1'b0 & eill;
`endif
        @(negedge clk);
        #1;
        bus_a.in_valid    = 1'b1;
        bus_a.ALUOp       = aop;
        bus_a.ALUFunction = fn;
        while (cyc < ready_at) begin
            @(negedge clk);
            #1;
        end
        acc = cyc;
        out_q.push_back('{cyc: cyc + 1, op: eop, jr: ejr, ill: ill_e});
        if (n > 0) begin
            md_q.push_back('{start: cyc + 1, done: cyc + n});
            ready_at = cyc + n + 1;
        end else begin
            ready_at = cyc + 1;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
            bus_a.in_valid = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        reset          = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        out_q.delete();
        md_q.delete();
        ready_at  = cyc + 1;
        hold_op   = 4'b1001;
        hold_jr   = 1'b0;
        ill_model = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         acc;
        logic [5:0] fn_b;
        logic [3:0] op_b;

        vecs = '{
            '{3'b111, 6'b100010, 4'b0100, 1'b0, 1'b0},
            '{3'b111, 6'b100100, 4'b0000, 1'b0, 1'b0},
            '{3'b100, 6'b100010, 4'b0011, 1'b0, 1'b0},
            '{3'b111, 6'b100101, 4'b0001, 1'b0, 1'b0},
            '{3'b101, 6'b000000, 4'b0001, 1'b0, 1'b0},
            '{3'b111, 6'b100111, 4'b0010, 1'b0, 1'b0},
            '{3'b110, 6'b100101, 4'b0000, 1'b0, 1'b0},
            '{3'b111, 6'b100000, 4'b0011, 1'b0, 1'b0},
            '{3'b001, 6'b100000, 4'b0100, 1'b0, 1'b0},
            '{3'b111, 6'b000000, 4'b0101, 1'b0, 1'b0},
            '{3'b010, 6'b011000, 4'b0111, 1'b0, 1'b0},
            '{3'b111, 6'b000010, 4'b0110, 1'b0, 1'b0},
            '{3'b011, 6'b011010, 4'b1000, 1'b0, 1'b0},
            '{3'b111, 6'b001000, 4'b1001, 1'b1, 1'b0},
            '{3'b111, 6'b010000, 4'b1110, 1'b0, 1'b0},
            '{3'b000, 6'b100000, 4'b1001, 1'b0, 1'b1},
            '{3'b111, 6'b010010, 4'b1111, 1'b0, 1'b0},
            '{3'b111, 6'b111111, 4'b1001, 1'b0, 1'b1}
        };

        bus_a.in_valid    = 1'b0;
        bus_a.ALUOp       = 3'b000;
        bus_a.ALUFunction = 6'b000000;
        bus_b.in_valid    = 1'b0;
        bus_b.ALUOp       = 3'b000;
        bus_b.ALUFunction = 6'b000000;

        repeat (2) @(negedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Single-cycle decodes back to back, including JR and illegal codes
        foreach (vecs[i]) begin
            issue(vecs[i].aop, vecs[i].fn, vecs[i].op, vecs[i].jr, vecs[i].ill, 0, acc);
        end
        idle(2);

        // Multi-cycle ops back to back; each next request is held until ready
        issue(3'b111, 6'b011000, 4'b1010, 1'b0, 1'b0, 4, acc);
        issue(3'b111, 6'b011001, 4'b1011, 1'b0, 1'b0, 4, acc);
        issue(3'b111, 6'b011010, 4'b1100, 1'b0, 1'b0, 32, acc);
        issue(3'b111, 6'b011011, 4'b1101, 1'b0, 1'b0, 32, acc);
        issue(3'b111, 6'b010000, 4'b1110, 1'b0, 1'b0, 0, acc);
        idle(2);

        // ADD held high during MULT BUSY
        issue(3'b111, 6'b011000, 4'b1010, 1'b0, 1'b0, 4, acc);
        issue(3'b111, 6'b100000, 4'b0011, 1'b0, 1'b0, 0, acc);
        idle(3);

        // Reset in the tenth BUSY cycle of a DIV; no md_done may follow
        issue(3'b111, 6'b011010, 4'b1100, 1'b0, 1'b0, 32, acc);
        idle(1);
        while (cyc < acc + 9) idle(1);
        apply_reset();
        idle(40);

        issue(3'b111, 6'b100010, 4'b0100, 1'b0, 1'b0, 0, acc);
        idle(3);

        // One-cycle MULT and DIV on the second instance
        for (int i = 0; i < 2; i++) begin
            fn_b = (i == 0) ? 6'b011000 : 6'b011010;
            op_b = (i == 0) ? 4'b1010 : 4'b1100;
            @(negedge clk);
            check("b pre in_ready", 32'(bus_b.in_ready), 32'd1);
            check("b pre busy", 32'(bus_b.busy), 32'd0);
            #1;
            bus_b.in_valid    = 1'b1;
            bus_b.ALUOp       = 3'b111;
            bus_b.ALUFunction = fn_b;
            @(negedge clk);
            check("b c1 out_valid", 32'(bus_b.out_valid), 32'd1);
            check("b c1 ALUOperation", 32'(bus_b.ALUOperation), 32'(op_b));
            check("b c1 md_start", 32'(bus_b.md_start), 32'd1);
            check("b c1 busy", 32'(bus_b.busy), 32'd1);
            check("b c1 md_done", 32'(bus_b.md_done), 32'd1);
            check("b c1 in_ready", 32'(bus_b.in_ready), 32'd0);
            #1;
            bus_b.in_valid = 1'b0;
            @(negedge clk);
            check("b c2 out_valid", 32'(bus_b.out_valid), 32'd0);
            check("b c2 md_start", 32'(bus_b.md_start), 32'd0);
            check("b c2 busy", 32'(bus_b.busy), 32'd0);
            check("b c2 md_done", 32'(bus_b.md_done), 32'd0);
            check("b c2 in_ready", 32'(bus_b.in_ready), 32'd1);
            check("b c2 ALUOperation", 32'(bus_b.ALUOperation), 32'(op_b));
        end

        idle(3);
        check("scoreboard drained", 32'(out_q.size() + md_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
